button_event_hub: RTL and testbench
===================================

# button_event_hub

Parametrised memory-mapped input peripheral for the Simon CPU. It replaces the fixed 4-bit debounced button/JD word with CHANNELS debounced inputs, per-channel edge detection, an event FIFO, a sticky overflow flag and an interrupt level. It sits on the CPU data-memory bus beside RAM. The top level muxes `read_data` into the processor's data input whenever `hit` is high.

## Interface
- CHANNELS, 8: number of input channels, 1..32.
- DB_CYCLES, 500000: consecutive stable cycles required to accept a new level.
- FIFO_DEPTH, 8: event FIFO entries, power of two, ≥2.
- BASE_ADDR, 1000: word address of register 0.
- clock  in  1  sole clock (CPU 50 MHz domain).
- reset  in  1  asynchronous, active-low; clears all state.
- raw_in  in  CHANNELS  undebounced, asynchronous pad inputs.
- address  in  32  CPU data address.
- wren  in  1  CPU write strobe.
- rden  in  1  CPU read strobe, one cycle per load.
- write_data  in  32  CPU store data.
- read_data  out  32  combinational register read data; 0 when `hit` is low.
- hit  out  1  combinational; high when address is in BASE_ADDR..BASE_ADDR+3.
- irq  out  1  registered; high while the FIFO is non-empty.

## Operation
- The register map is offset from BASE_ADDR.
- +0 LEVEL (RO):
  - [CHANNELS-1:0] holds the debounced levels.
  - Upper bits read 0.
- +1 EVENT (RO):
  - Fields: [31] valid, [8] kind (1 = rise, 0 = fall), [4:0] channel index.
  - A read with rden pops the head entry when the FIFO is non-empty.
  - When the FIFO is empty, the read returns 0 and nothing changes.
- +2 STATUS:
  - [15:8] FIFO count, [0] sticky overflow.
  - A write with write_data[0]=1 clears overflow.
- +3 CTRL (RW):
  - [CHANNELS-1:0] event enable mask.
  - [31] both-edges mode (0 = rising edges only).
- Debounce, per channel:
  - Input passes through a 2-FF synchroniser.
  - When the synchronised value differs from the debounced level, a counter increments; it clears whenever they are equal.
  - When the counter reaches DB_CYCLES-1 while they still differ, the level flips and the counter clears.
- Edge qualification:
  - A level flip on an enabled channel sets that channel's pending bit and kind bit.
  - A fall is qualified only when CTRL[31]=1.
- Arbiter:
  - At most one push per cycle, taken from the lowest-index pending channel.
  - A push happens only when the FIFO is not full, or a pop occurs the same cycle.
  - Pushing clears that channel's pending bit.
- Boundary cases:
  - New qualified edge on a channel whose pending bit is still set: the new edge is dropped, overflow is set, and the existing pending kind is kept.
  - FIFO full: pending bits hold, which gives back-pressure with no loss.
  - Full FIFO with pop and push in the same cycle: both take effect and the count is unchanged.
  - Clearing a CTRL mask bit clears that channel's pending bit; entries already in the FIFO remain.
  - Write to LEVEL or EVENT: ignored.
- Reset values:
  - All levels, counters, pending and FIFO state are 0; overflow is 0.
  - CTRL: mask is all ones and CTRL[31]=0.
  - irq is 0.

## Timing
- Raw input changes and stays stable from edge 0: LEVEL updates at edge 2+DB_CYCLES.
- A pending bit is set on the same edge as its level flip.
- The FIFO write occurs on the next edge, when unblocked.
- irq and STATUS count reflect the push after that edge.
- A pop occurs on the rden edge; the new head is visible in the next cycle.
- Both read_data and hit are combinational from address and state, with no read latency.
- Reset asserted mid-debounce or mid-FIFO clears state immediately.
- Deassertion is synchronised externally: reset is released on a clock-low phase.

## Structure
- Package `button_hub_pkg` holds:
  - the register offsets LEVEL/EVENT/STATUS/CTRL;
  - the EVENT field positions (VALID_BIT, KIND_BIT, CH_LSB/CH_MSB);
  - STATUS field positions;
  - the event entry typedef {kind, channel[4:0]}.
- Sub-module `input_debouncer` (parameter DB_CYCLES) contains the synchroniser, counter and level register, with a one-cycle `flip` output. It is instantiated CHANNELS times.
- The FIFO, arbiter and register decode live in the top of the block.

## Test plan
All scenarios use DB_CYCLES=4, FIFO_DEPTH=4, CHANNELS=8 and BASE_ADDR=1000.
- Reset, then read 1000/1001/1002/1003 -> 0x0, 0x0, 0x0, 0x000000FF; irq=0.
- raw_in[3] high for 3 cycles then low -> LEVEL stays 0 and no event is pushed.
- raw_in[3] held high -> LEVEL=0x08 at edge 6, irq=1 at edge 7, EVENT read=0x80000103. After rden, count=0 and irq=0.
- raw_in[0], raw_in[5] and raw_in[7] rise in the same cycle -> events pop in the order ch0, ch5, ch7, all with kind=1.
- CTRL=0x800000FF; toggle ch2 so that 6 qualified edges occur with no reads:
  - 4 events are queued, then a pending bit is held, then a colliding edge arrives.
  - Required: STATUS=0x00000401 (count 4, overflow 1).
  - Writing 1 to 1002 clears overflow, and the held event enters after the first pop.
- Assert reset while count=2 and a debounce is in progress -> all registers return to reset values on the same cycle.

Source files
------------

// File: rtl/button_hub_pkg.sv
// Shared register map, field positions and event entry type for button_event_hub.
package button_hub_pkg;

   // Word offsets from BASE_ADDR
   localparam logic [1:0] REG_LEVEL  = 2'd0;
   localparam logic [1:0] REG_EVENT  = 2'd1;
   localparam logic [1:0] REG_STATUS = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   // EVENT register fields
   localparam int unsigned VALID_BIT = 31;
   localparam int unsigned KIND_BIT  = 8;
   localparam int unsigned CH_LSB    = 0;
   localparam int unsigned CH_MSB    = 4;

   // STATUS register fields
   localparam int unsigned STAT_OVF_BIT = 0;
   localparam int unsigned STAT_CNT_LSB = 8;
   localparam int unsigned STAT_CNT_MSB = 15;

   // CTRL register fields
   localparam int unsigned CTRL_BOTH_BIT = 31;

   // One queued event: kind 1 = rise, 0 = fall
   typedef struct packed {
      logic       kind;
      logic [4:0] channel;
   } event_t;

   // Format a queued entry as the EVENT register word
   function automatic logic [31:0] pack_event(input event_t e);
      logic [31:0] r;
      r                 = '0;
      r[VALID_BIT]      = 1'b1;
      r[KIND_BIT]       = e.kind;
      r[CH_MSB:CH_LSB]  = e.channel;
      return r;
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Single-channel synchroniser + stability counter; flip pulses for one cycle when the level changes.
module input_debouncer #(
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic flip
);

   localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Next-state: count while synchronised input disagrees, flip on the last count
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      flip    = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_d = ~level_q;
            flip    = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/button_event_hub.sv
// Memory-mapped debounced input hub: per-channel edge events queued in a FIFO with irq.
module button_event_hub
   import button_hub_pkg::*;
#(
   parameter int unsigned CHANNELS   = 8,
   parameter int unsigned DB_CYCLES  = 500000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned BASE_ADDR  = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] raw_in,
   input  logic [31:0]         address,
   input  logic                wren,
   input  logic                rden,
   input  logic [31:0]         write_data,
   output logic [31:0]         read_data,
   output logic                hit,
   output logic                irq
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;

   logic [CHANNELS-1:0] level, flip;

   logic [CHANNELS-1:0] mask_q, mask_d;
   logic                both_q, both_d;
   logic                ovf_q, ovf_d;
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] kind_q, kind_d;
   event_t              mem_q [FIFO_DEPTH];
   event_t              mem_d [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic                irq_q, irq_d;

   logic [31:0]         offset;
   logic [1:0]          reg_sel;
   logic                pop, push, full, wr_status, wr_ctrl, found;
   logic [CHANNELS-1:0] grant;
   logic [4:0]          push_ch;
   event_t              head;
   logic [31:0]         rd_word;
   logic                unused_wdata;

   // One debouncer per channel
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      input_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clock (clock),
         .reset (reset),
         .raw   (raw_in[g]),
         .level (level[g]),
         .flip  (flip[g])
      );
   end

   // Address decode and bus strobes
   always_comb begin
      offset    = address - 32'(BASE_ADDR);
      hit       = (offset[31:2] == 30'd0);
      reg_sel   = offset[1:0];
      full      = (count_q == CNTW'(FIFO_DEPTH));
      pop       = hit && rden && (reg_sel == REG_EVENT) && (count_q != '0);
      wr_status = hit && wren && (reg_sel == REG_STATUS);
      wr_ctrl   = hit && wren && (reg_sel == REG_CTRL);
   end

   // Arbiter: lowest-index pending channel wins the single push slot
   always_comb begin
      grant   = '0;
      push_ch = '0;
      found   = 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (pend_q[i] && !found) begin
            grant[i] = 1'b1;
            push_ch  = 5'(i);
            found    = 1'b1;
         end
      end
      push = found && (!full || pop);
   end

   // Control, pending/overflow bookkeeping and FIFO next-state
   always_comb begin
      mask_d   = mask_q;
      both_d   = both_q;
      ovf_d    = ovf_q;
      pend_d   = pend_q;
      kind_d   = kind_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (wr_ctrl) begin
         mask_d = write_data[CHANNELS-1:0];
         both_d = write_data[CTRL_BOTH_BIT];
      end
      if (wr_status && write_data[STAT_OVF_BIT]) ovf_d = 1'b0;

      if (push) begin
         pend_d          = pend_d & ~grant;
         mem_d[wr_ptr_q] = '{kind: kind_q[push_ch], channel: push_ch};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase

      // A channel whose previous edge is still waiting keeps it; the new one is lost
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (flip[i] && mask_q[i] && (!level[i] || both_q)) begin
            if (pend_d[i]) begin
               ovf_d = 1'b1;
            end else begin
               pend_d[i] = 1'b1;
               kind_d[i] = ~level[i];
            end
         end
      end

      pend_d = pend_d & mask_d;
      irq_d  = (count_d != '0);
   end

   // State registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mask_q   <= '1;
         both_q   <= 1'b0;
         ovf_q    <= 1'b0;
         pend_q   <= '0;
         kind_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         irq_q    <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         mask_q   <= mask_d;
         both_q   <= both_d;
         ovf_q    <= ovf_d;
         pend_q   <= pend_d;
         kind_q   <= kind_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         irq_q    <= irq_d;
         mem_q    <= mem_d;
      end
   end

   // Register read mux, zero outside the window
   always_comb begin
      head    = mem_q[rd_ptr_q];
      rd_word = '0;
      case (reg_sel)
         REG_LEVEL:  rd_word = 32'(level);
         REG_EVENT:  if (count_q != '0) rd_word = pack_event(head);
         REG_STATUS: begin
            rd_word[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(count_q);
            rd_word[STAT_OVF_BIT]              = ovf_q;
         end
         default: begin
            rd_word                = 32'(mask_q);
            rd_word[CTRL_BOTH_BIT] = both_q;
         end
      endcase
      read_data = hit ? rd_word : 32'd0;
   end

   assign irq          = irq_q;
   assign unused_wdata = ^write_data;

endmodule

// File: tb/tb_button_event_hub.sv
// Directed bench for button_event_hub with DB_CYCLES=4, FIFO_DEPTH=4, CHANNELS=8, BASE_ADDR=1000.
module tb_button_event_hub;

   localparam int unsigned CH   = 8;
   localparam int unsigned DB   = 4;
   localparam int unsigned FD   = 4;
   localparam int unsigned BASE = 1000;

   logic          clock = 1'b0;
   logic          reset;
   logic [CH-1:0] raw_in;
   logic [31:0]   address, write_data, read_data;
   logic          wren, rden, hit, irq;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_hit;
   } vec_t;

   vec_t vecs[14];

   button_event_hub #(
      .CHANNELS(CH), .DB_CYCLES(DB), .FIFO_DEPTH(FD), .BASE_ADDR(BASE)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .raw_in     (raw_in),
      .address    (address),
      .wren       (wren),
      .rden       (rden),
      .write_data (write_data),
      .read_data  (read_data),
      .hit        (hit),
      .irq        (irq)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      address = a;
      #1;
      check(name, read_data, exp);
   endtask

   task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
      address    = a;
      write_data = d;
      wren       = 1'b1;
      tick();
      wren       = 1'b0;
      write_data = '0;
   endtask

   task automatic pop_check(input string name, input logic [31:0] exp);
      address = 32'(BASE + 1);
      rden    = 1'b1;
      #1;
      check(name, read_data, exp);
      tick();
      rden = 1'b0;
   endtask

   initial begin
      // addr, expected read_data (value before any write lands), expected hit
      vecs[0]  = '{1'b0, 1'b1, 32'd1000, 32'h0,        32'h0000_0000, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 32'd1001, 32'h0,        32'h0000_0000, 1'b1};
      vecs[2]  = '{1'b0, 1'b1, 32'd1002, 32'h0,        32'h0000_0000, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 32'd1003, 32'h0,        32'h0000_00FF, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 32'd999,  32'h0,        32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'd1004, 32'h0,        32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'd1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'd1000, 32'h0,        32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 32'd1003, 32'h8000_00F0, 32'h0000_00FF, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 32'd1003, 32'h0,        32'h8000_00F0, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 32'd1003, 32'h0000_00FF, 32'h8000_00F0, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 32'd1001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 32'd1002, 32'h0,        32'h0000_0000, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 32'd1003, 32'h0,        32'h0000_00FF, 1'b1};

      reset      = 1'b0;
      raw_in     = '0;
      address    = '0;
      write_data = '0;
      wren       = 1'b0;
      rden       = 1'b0;
      ticks(3);
      @(negedge clock);
      reset = 1'b1;
      tick();

      // Reset values and register map
      check("reset_irq", 32'(irq), 32'd0);
      for (int v = 0; v < 14; v++) begin
         address    = vecs[v].addr;
         write_data = vecs[v].wdata;
         wren       = vecs[v].wr;
         rden       = vecs[v].rd;
         #1;
         check($sformatf("vec%0d_rdata", v), read_data, vecs[v].exp_rdata);
         check($sformatf("vec%0d_hit", v), 32'(hit), 32'(vecs[v].exp_hit));
         tick();
         wren = 1'b0;
         rden = 1'b0;
      end

      // Three-cycle glitch is rejected
      raw_in[3] = 1'b1;
      ticks(3);
      raw_in[3] = 1'b0;
      ticks(10);
      check_reg("glitch_level", BASE, 32'h0);
      check_reg("glitch_status", BASE + 2, 32'h0);
      check("glitch_irq", 32'(irq), 32'd0);

      // Held input: level at edge 6, irq at edge 7
      tick();
      raw_in[3] = 1'b1;
      ticks(5);
      check_reg("db_level_edge5", BASE, 32'h0);
      tick();
      check_reg("db_level_edge6", BASE, 32'h08);
      check("db_irq_edge6", 32'(irq), 32'd0);
      tick();
      check("db_irq_edge7", 32'(irq), 32'd1);
      check_reg("db_status", BASE + 2, 32'h0000_0100);
      pop_check("db_event", 32'h8000_0103);
      check_reg("db_status_after_pop", BASE + 2, 32'h0);
      check("db_irq_after_pop", 32'(irq), 32'd0);

      // Simultaneous rises drain in channel order
      raw_in[0] = 1'b1;
      raw_in[5] = 1'b1;
      raw_in[7] = 1'b1;
      ticks(10);
      check_reg("multi_status", BASE + 2, 32'h0000_0300);
      check_reg("multi_level", BASE, 32'h0000_00A9);
      pop_check("multi_ev0", 32'h8000_0100);
      pop_check("multi_ev5", 32'h8000_0105);
      pop_check("multi_ev7", 32'h8000_0107);
      pop_check("multi_empty", 32'h0);
      check_reg("multi_status_end", BASE + 2, 32'h0);

      // Both edges on ch2: 4 queued, 1 held, 1 collision
      write_reg(BASE + 3, 32'h8000_00FF);
      for (int k = 0; k < 6; k++) begin
         raw_in[2] = ~raw_in[2];
         ticks(8);
      end
      check_reg("ovf_status", BASE + 2, 32'h0000_0401);
      check("ovf_irq", 32'(irq), 32'd1);
      write_reg(BASE + 2, 32'h1);
      check_reg("ovf_cleared", BASE + 2, 32'h0000_0400);
      pop_check("ovf_ev0", 32'h8000_0102);
      check_reg("ovf_refill_count", BASE + 2, 32'h0000_0400);
      pop_check("ovf_ev1", 32'h8000_0002);
      pop_check("ovf_ev2", 32'h8000_0102);
      pop_check("ovf_ev3", 32'h8000_0002);
      pop_check("ovf_ev_held", 32'h8000_0102);
      check_reg("ovf_status_end", BASE + 2, 32'h0);
      check("ovf_irq_end", 32'(irq), 32'd0);

      // Reset mid-FIFO and mid-debounce
      write_reg(BASE + 3, 32'h8000_007F);
      raw_in[1] = 1'b1;
      ticks(8);
      raw_in[4] = 1'b1;
      ticks(8);
      check_reg("pre_rst_status", BASE + 2, 32'h0000_0200);
      raw_in[6] = 1'b1;
      ticks(3);
      #1;
      reset = 1'b0;
      check_reg("rst_level", BASE, 32'h0);
      check_reg("rst_event", BASE + 1, 32'h0);
      check_reg("rst_status", BASE + 2, 32'h0);
      check_reg("rst_ctrl", BASE + 3, 32'h0000_00FF);
      check("rst_irq", 32'(irq), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // Inputs still high re-debounce; 7 rises back-pressure behind a full FIFO
      ticks(12);
      check_reg("post_rst_level", BASE, 32'h0000_00FB);
      check_reg("post_rst_full", BASE + 2, 32'h0000_0400);
      check("post_rst_irq", 32'(irq), 32'd1);
      pop_check("post_rst_ev0", 32'h8000_0100);
      check_reg("post_rst_refill", BASE + 2, 32'h0000_0400);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
